run_sequencer: RTL

Hardware run controller for the `singlecycle` processor. It takes the processor through one test program: reset, free-run until the PC reaches a target, settle, then check the data-memory output against an expected value. A watchdog bounds every run. The block sits beside `singlecycle` in the test harness and drives its `resetl` and `startpc` inputs, so one program can be launched per `start` pulse.

---
 rtl/run_sequencer_pkg.sv | 22 ++
 rtl/run_watchdog.sv | 31 +++
 rtl/run_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared types and widths for the run sequencer.
// Used by run_sequencer and run_watchdog.
package run_sequencer_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        SETTLE,
        CHECK
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// Run watchdog: clearable saturating counter that flags the
// edge on which the count would reach LIMIT.
module run_watchdog
    import run_sequencer_pkg::*;
#(
    parameter logic [CNT_W-1:0] LIMIT = 16'h00FF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_nxt;

    always_comb begin
        cnt_nxt = {1'b0, cnt} + 1'b1;
        expired = en && (cnt_nxt >= {1'b0, LIMIT});
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run controller for singlecycle: reset, run to end_pc, settle, check.
// Optional live cycle counter: RUN_SEQUENCER_CYCLE_COUNT_EN.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int               RESET_CYCLES  = 1,
    parameter int               SETTLE_CYCLES = 1,
    parameter logic [CNT_W-1:0] WDOG_LIMIT    = 16'h00FF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] start_pc_in,
    input  logic [DATA_W-1:0] end_pc,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] currentpc,
    input  logic [DATA_W-1:0] dmemout,
    output logic              proc_resetl,
    output logic [DATA_W-1:0] startpc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [CNT_W-1:0] RST_LAST =
        CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST =
        CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  phase_cnt;
    logic [DATA_W-1:0] end_pc_q;
    logic [DATA_W-1:0] expected_q;

    logic pc_hit;
    logic settle_last;
    logic wdog_clr;
    logic wdog_en;
    logic expired;

    always_comb begin
        pc_hit      = currentpc >= end_pc_q;
        settle_last = phase_cnt == SET_LAST;
        wdog_clr    = (state == IDLE) && start;
        wdog_en     = (state == RUN) || (state == SETTLE);
    end

    run_watchdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk    (CLK),
        .reset  (reset),
        .clear  (wdog_clr),
        .en     (wdog_en),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            end_pc_q    <= '0;
            expected_q  <= '0;
            startpc     <= '0;
            proc_resetl <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        startpc    <= start_pc_in;
                        end_pc_q   <= end_pc;
                        expected_q <= expected;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        phase_cnt  <= '0;
                        busy       <= 1'b1;
                        state      <= RESET;
                    end
                end
                RESET: begin
                    if (phase_cnt == RST_LAST) begin
                        phase_cnt   <= '0;
                        proc_resetl <= 1'b1;
                        state       <= RUN;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Expiry wins over a PC match on the same edge.
                    if (expired) begin
                        timeout     <= 1'b1;
                        pass        <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        proc_resetl <= 1'b0;
                        state       <= IDLE;
                    end else if (pc_hit) begin
                        phase_cnt <= '0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (expired) begin
                        timeout     <= 1'b1;
                        pass        <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        proc_resetl <= 1'b0;
                        state       <= IDLE;
                    end else if (settle_last) begin
                        pass  <= dmemout == expected_q;
                        done  <= 1'b1;
                        state <= CHECK;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    busy        <= 1'b0;
                    proc_resetl <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    proc_resetl <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
    logic cc_inc;

    // The edge that leaves SETTLE for CHECK is not counted.
    always_comb begin
        cc_inc = 1'b0;
        if (!expired) begin
            if (state == RUN) begin
                cc_inc = 1'b1;
            end else if (state == SETTLE) begin
                cc_inc = !settle_last;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (wdog_clr) begin
            cycle_count <= '0;
        end else if (cc_inc) begin
            cycle_count <= sat_inc(cycle_count);
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule
